// File: rtl/uart_config_decoder_if.sv
// RX byte stream and TX echo handshake seen by uart_config_decoder.
// Signal suffixes are from the decoder's point of view (slave modport).
interface uart_config_decoder_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] ack_data_o;
  logic       ack_valid_o;
  logic       ack_ready_i;

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    input  ack_ready_i,
    output ack_data_o,
    output ack_valid_o
  );

  modport master (
    output rx_data_i,
    output rx_valid_i,
    output ack_ready_i,
    input  ack_data_o,
    input  ack_valid_o
  );
endinterface

// File: rtl/uart_config_decoder.sv
// Decodes {dont_care, option, id} config packets into a shadow UART config and commits it on END.
// Optional echo of accepted packets back to TX is enabled with `define CONFIG_ECHO_EN.
module uart_config_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  uart_config_decoder_if.slave         bus,
  output logic [5:0]                   config_o,
  output logic                         cfg_active_o,
  output logic                         cfg_done_o,
  output logic                         cfg_error_o,
  output logic                         cfg_timeout_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    END_CONFIGURATION_ID = 2'b00,
    DATA_WIDTH_ID        = 2'b01,
    PARITY_MODE_ID       = 2'b10,
    STOP_BITS_ID         = 2'b11
  } cfg_id_e;

  typedef struct packed {
    logic [1:0] data_width;
    logic [1:0] parity_mode;
    logic [1:0] stop_bits;
  } uart_config_s;

  typedef struct packed {
    logic [3:0] dont_care;
    logic [1:0] option;
    cfg_id_e    id;
  } data_packet_s;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PKT,
    ST_ACK
  } state_e;

  localparam uart_config_s STD_CONFIGURATION = '{data_width: 2'b11, parity_mode: 2'b00, stop_bits: 2'b00};

  state_e              state_q;
  uart_config_s        config_q;
  uart_config_s        shadow_q;
  logic [TimerW-1:0]   timer_q;
  logic                active_q;
  logic                done_q;
  logic                error_q;
  logic                timeout_q;

  data_packet_s        rx_pkt;
  logic                pkt_legal;
  logic                timer_expired;
  logic [3:0]          unused_dont_care;

  assign rx_pkt           = data_packet_s'(bus.rx_data_i);
  assign unused_dont_care = rx_pkt.dont_care;

  // Stop-bit codes with option[1] set are the two reserved encodings.
  assign pkt_legal     = !((rx_pkt.id == STOP_BITS_ID) && rx_pkt.option[1]);
  assign timer_expired = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

`ifdef CONFIG_ECHO_EN
  logic [7:0] ack_data_q;
  logic       ack_valid_q;
  logic       ack_end_q;
`endif

  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values of each other; a blocking = here would chain updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      config_q    <= STD_CONFIGURATION;
      shadow_q    <= STD_CONFIGURATION;
      timer_q     <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef CONFIG_ECHO_EN
      ack_data_q  <= '0;
      ack_valid_q <= 1'b0;
      ack_end_q   <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cfg_req_i) begin
            state_q  <= ST_WAIT_PKT;
            active_q <= 1'b1;
            shadow_q <= config_q;
            timer_q  <= '0;
          end
        end

        ST_WAIT_PKT: begin
          if (bus.rx_valid_i) begin
            timer_q <= '0;
            if (!pkt_legal) begin
              error_q <= 1'b1;
            end else begin
              case (rx_pkt.id)
                DATA_WIDTH_ID:  shadow_q.data_width  <= rx_pkt.option;
                PARITY_MODE_ID: shadow_q.parity_mode <= rx_pkt.option;
                STOP_BITS_ID:   shadow_q.stop_bits   <= rx_pkt.option;
                default: begin
                  config_q <= shadow_q;
                  done_q   <= 1'b1;
                end
              endcase
`ifdef CONFIG_ECHO_EN
              state_q     <= ST_ACK;
              ack_valid_q <= 1'b1;
              ack_data_q  <= {4'h0, rx_pkt.option, rx_pkt.id};
              ack_end_q   <= (rx_pkt.id == END_CONFIGURATION_ID);
`else
              if (rx_pkt.id == END_CONFIGURATION_ID) begin
                state_q  <= ST_IDLE;
                active_q <= 1'b0;
              end
`endif
            end
          end else if (timer_expired) begin
            // Abort: the shadow is reloaded from config_q on the next request.
            state_q   <= ST_IDLE;
            active_q  <= 1'b0;
            timeout_q <= 1'b1;
            shadow_q  <= config_q;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

`ifdef CONFIG_ECHO_EN
        ST_ACK: begin
          // Timer is frozen here; bytes arriving while TX is busy are dropped.
          if (bus.rx_valid_i) begin
            error_q <= 1'b1;
          end
          if (bus.ack_ready_i) begin
            ack_valid_q <= 1'b0;
            ack_data_q  <= '0;
            timer_q     <= '0;
            if (ack_end_q) begin
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
            end else begin
              state_q <= ST_WAIT_PKT;
            end
          end
        end
`endif

        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign config_o      = config_q;
  assign cfg_active_o  = active_q;
  assign cfg_done_o    = done_q;
  assign cfg_error_o   = error_q;
  assign cfg_timeout_o = timeout_q;

`ifdef CONFIG_ECHO_EN
  assign bus.ack_data_o  = ack_data_q;
  assign bus.ack_valid_o = ack_valid_q;

  a_ack_held : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.ack_valid_o && !bus.ack_ready_i) |=> bus.ack_valid_o);
`else
  logic unused_ack_ready;
  assign unused_ack_ready = bus.ack_ready_i;
  assign bus.ack_data_o   = '0;
  assign bus.ack_valid_o  = 1'b0;
`endif

  a_done_timeout_excl : assert property (@(posedge clk_i) disable iff (rst_i)
    !(cfg_done_o && cfg_timeout_o));
  a_done_error_excl : assert property (@(posedge clk_i) disable iff (rst_i)
    !(cfg_done_o && cfg_error_o));

endmodule

// File: tb/tb_uart_config_decoder.sv
// Self-checking bench for uart_config_decoder: directed scenarios plus random traffic
// compared every cycle against a packet-level reference model.
module tb_uart_config_decoder;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [5:0]  STD_CFG = 6'b11_00_00;

`ifdef CONFIG_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cfg_req_i;
  logic [5:0] config_o;
  logic       cfg_active_o;
  logic       cfg_done_o;
  logic       cfg_error_o;
  logic       cfg_timeout_o;

  uart_config_decoder_if bus ();

  uart_config_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cfg_req_i     (cfg_req_i),
    .bus           (bus),
    .config_o      (config_o),
    .cfg_active_o  (cfg_active_o),
    .cfg_done_o    (cfg_done_o),
    .cfg_error_o   (cfg_error_o),
    .cfg_timeout_o (cfg_timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: committed/shadow configs, mode flags and an idle-cycle count.
  logic [5:0] m_cfg     = STD_CFG;
  logic [5:0] m_shadow  = STD_CFG;
  bit         m_active  = 1'b0;
  bit         m_acking  = 1'b0;
  bit         m_ack_end = 1'b0;
  logic [7:0] m_ack_data = 8'h00;
  int         m_idle    = 0;
  bit         m_done, m_err, m_to;

  int done_seen = 0;
  int err_seen  = 0;
  int to_seen   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit req, input bit valid,
                            input logic [7:0] data, input bit ready);
    logic [1:0] id;
    logic [1:0] opt;
    id  = data[1:0];
    opt = data[3:2];
    m_done = 1'b0;
    m_err  = 1'b0;
    m_to   = 1'b0;
    if (rst) begin
      m_cfg = STD_CFG; m_shadow = STD_CFG; m_active = 1'b0; m_acking = 1'b0;
      m_ack_end = 1'b0; m_ack_data = 8'h00; m_idle = 0;
    end else if (!m_active) begin
      if (req) begin
        m_active = 1'b1;
        m_shadow = m_cfg;
        m_idle   = 0;
      end
    end else if (m_acking) begin
      if (valid) m_err = 1'b1;
      if (ready) begin
        m_acking   = 1'b0;
        m_ack_data = 8'h00;
        m_idle     = 0;
        if (m_ack_end) m_active = 1'b0;
      end
    end else if (valid) begin
      m_idle = 0;
      if (id == 2'd3 && opt >= 2'd2) begin
        m_err = 1'b1;
      end else begin
        if (id == 2'd1) m_shadow[5:4] = opt;
        if (id == 2'd2) m_shadow[3:2] = opt;
        if (id == 2'd3) m_shadow[1:0] = opt;
        if (id == 2'd0) begin
          m_cfg  = m_shadow;
          m_done = 1'b1;
        end
        if (ECHO) begin
          m_acking   = 1'b1;
          m_ack_data = {4'h0, opt, id};
          m_ack_end  = (id == 2'd0);
        end else if (id == 2'd0) begin
          m_active = 1'b0;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_to     = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit req, input bit valid,
                      input logic [7:0] data, input bit ready);
    @(negedge clk);
    rst_i          = rst;
    cfg_req_i      = req;
    bus.rx_valid_i = valid;
    bus.rx_data_i  = data;
    bus.ack_ready_i = ready;
    @(posedge clk);
    model_step(rst, req, valid, data, ready);
    #1;
    check("config_o",      config_o,        m_cfg);
    check("cfg_active_o",  cfg_active_o,    m_active);
    check("cfg_done_o",    cfg_done_o,      m_done);
    check("cfg_error_o",   cfg_error_o,     m_err);
    check("cfg_timeout_o", cfg_timeout_o,   m_to);
    check("ack_valid_o",   bus.ack_valid_o, m_acking);
    check("ack_data_o",    bus.ack_data_o,  m_ack_data);
    if (cfg_done_o)    done_seen++;
    if (cfg_error_o)   err_seen++;
    if (cfg_timeout_o) to_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send(input logic [7:0] data);
    step(1'b0, 1'b0, 1'b1, data, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic enter_cfg();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  int base;

  initial begin
    rst_i = 1'b1; cfg_req_i = 1'b0;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00; bus.ack_ready_i = 1'b1;

    // Reset state
    do_reset();
    check("rst_config", config_o, STD_CFG);
    check("rst_active", cfg_active_o, 1'b0);

    // Full configuration sequence and commit
    base = done_seen;
    enter_cfg();
    send(8'h09); send(8'h06); send(8'h07); send(8'h00);
    idle(2);
    check("seq_commit_cfg", config_o, 6'b10_01_01);
    check("seq_done_once", done_seen - base, 1);
    check("seq_active_low", cfg_active_o, 1'b0);

    // Reserved stop-bit code
    do_reset();
    base = err_seen;
    enter_cfg();
    send(8'h0B); send(8'h00);
    idle(2);
    check("reserved_err_once", err_seen - base, 1);
    check("reserved_cfg", config_o, STD_CFG);

    // Timeout after one packet
    base = to_seen;
    enter_cfg();
    send(8'h09);
    idle(TIMEOUT + 4);
    check("timeout_once", to_seen - base, 1);
    check("timeout_cfg", config_o, STD_CFG);
    check("timeout_idle", cfg_active_o, 1'b0);

    // Packet on the 15th idle cycle keeps the session alive
    base = to_seen;
    enter_cfg();
    send(8'h09);
    idle(TIMEOUT - 3);
    send(8'h06);
    send(8'h00);
    check("no_timeout", to_seen - base, 0);
    check("late_commit_cfg", config_o, 6'b10_01_00);

`ifdef CONFIG_ECHO_EN
    // Echo held while TX stalls; a byte arriving meanwhile is dropped
    do_reset();
    base = err_seen;
    enter_cfg();
    step(1'b0, 1'b0, 1'b1, 8'hF9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, (i == 2), 8'h06, 1'b0);
      check("echo_data_held", bus.ack_data_o, 8'h09);
      check("echo_valid_held", bus.ack_valid_o, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("echo_drop_err", err_seen - base, 1);
    send(8'h00);
    idle(1);
    check("echo_commit_cfg", config_o, 6'b10_00_00);
`endif

    // Reset mid-session restores the standard configuration
    do_reset();
    enter_cfg();
    send(8'h09); send(8'h06); send(8'h07); send(8'h00);
    idle(1);
    check("pre_reset_cfg", config_o, 6'b10_01_01);
    enter_cfg();
    step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("mid_reset_cfg", config_o, STD_CFG);
    check("mid_reset_active", cfg_active_o, 1'b0);
    check("mid_reset_ack", bus.ack_valid_o, 1'b0);

    // Byte in IDLE is ignored
    base = done_seen + err_seen + to_seen;
    step(1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
    idle(2);
    check("idle_byte_pulses", done_seen + err_seen + to_seen - base, 0);
    check("idle_byte_cfg", config_o, STD_CFG);
    check("idle_byte_active", cfg_active_o, 1'b0);

    // Random traffic against the model, alternating busy and quiet phases
    for (int c = 0; c < 4000; c++) begin
      bit r, q, v, k, quiet;
      logic [7:0] d;
      quiet = ((c / 500) % 2) == 1;
      r = ($urandom_range(0, 199) == 0);
      q = ($urandom_range(0, 7) == 0);
      v = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      k = ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      step(r, q, v, d, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
